subtree_rr_arbiter: RTL

Round-robin packet arbiter sharing one downstream stream port among the child instances of a generated hierarchy level; default of two requesters matches the two-child fan-out used at each level. Each requester holds the grant for a whole packet (until a beat with last is accepted). A stall watchdog force-releases a grant whose owner stops making progress. The arbiter sits between the child instances and the parent-level shared resource.

---
 rtl/subtree_rr_arbiter_if.sv | 30 +++
 rtl/subtree_rr_arbiter.sv | 127 ++++++++++++
 2 files changed

// File: rtl/subtree_rr_arbiter_if.sv
// Stream port bundle between the child requesters of one hierarchy level and
// the shared parent-level consumer.
interface subtree_rr_arbiter_if #(
  parameter int N_REQ  = 2,
  parameter int DATA_W = 32
);
  localparam int SRC_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        req_last;
  logic [N_REQ-1:0]        req_ready;
  logic                    out_valid;
  logic [DATA_W-1:0]       out_data;
  logic                    out_last;
  logic [SRC_W-1:0]        out_src;
  logic                    out_ready;
  logic [N_REQ-1:0]        grant;
  logic                    stall_timeout;

  // master: requesters plus downstream consumer; slave: the arbiter
  modport master (
    output req_valid, req_data, req_last, out_ready,
    input  req_ready, out_valid, out_data, out_last, out_src, grant, stall_timeout
  );
  modport slave (
    input  req_valid, req_data, req_last, out_ready,
    output req_ready, out_valid, out_data, out_last, out_src, grant, stall_timeout
  );
endinterface

// File: rtl/subtree_rr_arbiter.sv
// Packet-granular round-robin arbiter for one shared stream port, with a stall
// watchdog that force-releases an owner that stops making progress.
module subtree_rr_lane #(
  parameter int DATA_W = 32
) (
  input  logic              sel,
  input  logic              valid,
  input  logic [DATA_W-1:0] data,
  input  logic              last,
  input  logic              down_ready,
  output logic              ready,
  output logic              valid_m,
  output logic [DATA_W-1:0] data_m,
  output logic              last_m
);
  // Non-selected lanes contribute zeros so the top can OR-reduce.
  assign ready   = sel & down_ready;
  assign valid_m = sel & valid;
  assign data_m  = sel ? data : '0;
  assign last_m  = sel & last;
endmodule

module subtree_rr_arbiter #(
  parameter int N_REQ     = 2,
  parameter int DATA_W    = 32,
  parameter int MAX_STALL = 16
) (
  input logic                 clk,
  input logic                 rst,
  subtree_rr_arbiter_if.slave bus
);
  localparam int SRC_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {IDLE, GRANTED} state_t;

  state_t                       state;
  logic [SRC_W-1:0]             owner, ptr, winner, nxt;
  logic [7:0]                   stall_cnt;
  logic                         any_req, hs;
  logic [N_REQ-1:0]             sel, valid_m, last_m;
  logic [N_REQ-1:0][DATA_W-1:0] data_m;

  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    assign sel[i] = (state == GRANTED) && (owner == SRC_W'(i));
    subtree_rr_lane #(.DATA_W(DATA_W)) u_lane (
      .sel       (sel[i]),
      .valid     (bus.req_valid[i]),
      .data      (bus.req_data[i*DATA_W +: DATA_W]),
      .last      (bus.req_last[i]),
      .down_ready(bus.out_ready),
      .ready     (bus.req_ready[i]),
      .valid_m   (valid_m[i]),
      .data_m    (data_m[i]),
      .last_m    (last_m[i])
    );
  end

  always_comb begin
    bus.out_data = '0;
    for (int i = 0; i < N_REQ; i++) bus.out_data = bus.out_data | data_m[i];
  end

  assign bus.grant     = sel;
  assign bus.out_valid = |valid_m;
  assign bus.out_last  = |last_m;
  assign bus.out_src   = (state == GRANTED) ? owner : '0;
  assign hs            = bus.out_valid & bus.out_ready;
  assign any_req       = |bus.req_valid;
  assign nxt           = (owner == SRC_W'(N_REQ - 1)) ? '0 : owner + 1'b1;

  // First valid requester at or after ptr, wrapping modulo N_REQ.
  always_comb begin
    logic             found;
    logic [SRC_W-1:0] cand;
    int               j;
    winner = ptr;
    found  = 1'b0;
    cand   = '0;
    j      = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j    = (int'(ptr) + k) % N_REQ;
      cand = SRC_W'(j);
      if (!found && bus.req_valid[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      owner             <= '0;
      ptr               <= '0;
      stall_cnt         <= '0;
      bus.stall_timeout <= 1'b0;
    end else begin
      bus.stall_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            owner     <= winner;
            stall_cnt <= '0;
            state     <= GRANTED;
          end
        end
        GRANTED: begin
          // A handshake on the threshold cycle beats the watchdog.
          if (hs) begin
            stall_cnt <= '0;
            if (bus.out_last) begin
              state <= IDLE;
              ptr   <= nxt;
            end
          end else if (stall_cnt == 8'(MAX_STALL - 1)) begin
            state             <= IDLE;
            ptr               <= nxt;
            stall_cnt         <= '0;
            bus.stall_timeout <= 1'b1;
          end else begin
            stall_cnt <= stall_cnt + 8'd1;
          end
        end
      endcase
    end
  end
endmodule
